// File: rtl/mcp3202_pkg.sv
// Shared types and constants for the MCP3202 conversion scheduler.
// FSM encoding, channel ids and datapath widths.
package mcp3202_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_HOLD
    } state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int SAMPLE_W = 12;
    localparam int AXIS_W   = 16;

    // Clock cycles one SPI conversion takes in the engine.
    localparam int CONV_CLKS = 15300;

    function automatic int unsigned period_of(
        input int unsigned fclk,
        input int unsigned fs
    );
        return fclk / fs;
    endfunction

endpackage

// File: rtl/mcp3202_tick_gen.sv
// Per-channel sample tick generator.
// Fires one cycle every PERIOD cycles while enabled.
module mcp3202_tick_gen #(
    parameter int unsigned PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    // Free-running period counter, parked at zero while disabled.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/mcp3202_conv_scheduler.sv
// Round-robin conversion scheduler for a shared MCP3202 SPI engine.
// Issues one conversion at a time and streams tagged samples out.
module mcp3202_conv_scheduler
    import mcp3202_pkg::*;
#(
    parameter int unsigned FCLK      = 100_000_000,
    parameter int unsigned FSMPL_CH0 = 500,
    parameter int unsigned FSMPL_CH1 = 500,
    parameter bit          SGL       = 1'b1,
    parameter int unsigned TIMEOUT   = 20000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          en,
    input  logic                clr_err,
    output logic                conv_start,
    output logic                conv_sgl,
    output logic                conv_odd,
    input  logic                conv_done,
    input  logic [SAMPLE_W-1:0] conv_data,
    output logic [AXIS_W-1:0]   m_axis_tdata,
    output logic                m_axis_tuser,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [1:0]          overrun,
    output logic                timeout
);

    localparam int unsigned P0 = period_of(FCLK, FSMPL_CH0);
    localparam int unsigned P1 = period_of(FCLK, FSMPL_CH1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t state;
    state_t state_n;

    logic [1:0]    tick;
    logic [1:0]    pending;
    logic [1:0]    pending_n;
    logic [1:0]    grant_vec;
    logic [1:0]    ov_set;
    logic [1:0]    overrun_n;
    logic          timeout_n;
    logic          grant;
    logic          issue;
    logic          capture;
    logic          tmo_evt;
    logic          cur_ch;
    logic          last_grant;
    logic [TW-1:0] tmo_cnt;

    mcp3202_tick_gen #(.PERIOD(P0)) u_tick0 (
        .clk  (clk),
        .rst  (rst),
        .en   (en[0]),
        .tick (tick[0])
    );

    mcp3202_tick_gen #(.PERIOD(P1)) u_tick1 (
        .clk  (clk),
        .rst  (rst),
        .en   (en[1]),
        .tick (tick[1])
    );

    // Round-robin pick: a lone request wins, a tie goes to the other channel.
    always_comb begin
        grant = CH0;
        if (pending == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = pending[1] ? CH1 : CH0;
        end
    end

    // Next-state and control strobes of the conversion FSM.
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        capture = 1'b0;
        tmo_evt = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (|pending) begin
                    issue   = 1'b1;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_n = ST_BUSY;
            end
            ST_BUSY: begin
                if (conv_done) begin
                    capture = 1'b1;
                    state_n = ST_HOLD;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_evt = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (m_axis_tready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Request bookkeeping; a tick coinciding with its own grant re-arms.
    always_comb begin
        grant_vec = 2'b00;
        if (issue) begin
            grant_vec = grant ? 2'b10 : 2'b01;
        end
        ov_set    = tick & pending & ~grant_vec;
        pending_n = en & (tick | (pending & ~grant_vec));
        overrun_n = (clr_err ? 2'b00 : overrun) | ov_set;
        timeout_n = (clr_err ? 1'b0 : timeout) | tmo_evt;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Channel latch, watchdog, output register and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= 2'b00;
            cur_ch       <= CH0;
            last_grant   <= CH1;
            conv_sgl     <= 1'b0;
            tmo_cnt      <= '0;
            m_axis_tdata <= '0;
            m_axis_tuser <= 1'b0;
            overrun      <= 2'b00;
            timeout      <= 1'b0;
        end else begin
            pending <= pending_n;
            overrun <= overrun_n;
            timeout <= timeout_n;
            if (issue) begin
                cur_ch     <= grant;
                last_grant <= grant;
                conv_sgl   <= SGL;
            end
            if (state == ST_ISSUE) begin
                tmo_cnt <= '0;
            end else if (state == ST_BUSY) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (capture) begin
                m_axis_tdata <= {{(AXIS_W - SAMPLE_W){1'b0}}, conv_data};
                m_axis_tuser <= cur_ch;
            end
        end
    end

    assign conv_start    = (state == ST_ISSUE);
    assign conv_odd      = cur_ch;
    assign m_axis_tvalid = (state == ST_HOLD);

endmodule

// File: tb/tb_mcp3202_conv_scheduler.sv
// Directed bench for mcp3202_conv_scheduler.
// Fast engine model, P0 = P1 = 1000 cycles.
module tb_mcp3202_conv_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  en = 2'b00;
    logic        clr_err = 1'b0;
    logic        conv_start;
    logic        conv_sgl;
    logic        conv_odd;
    logic        conv_done;
    logic [11:0] conv_data;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [1:0]  overrun;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    bit eng_on = 1'b1;
    int eng_lat = 4;
    int starts = 0;
    int starts_odd1 = 0;

    always #5 clk = ~clk;

    mcp3202_conv_scheduler #(
        .FCLK      (100_000_000),
        .FSMPL_CH0 (100_000),
        .FSMPL_CH1 (100_000),
        .SGL       (1'b1),
        .TIMEOUT   (20000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .clr_err       (clr_err),
        .conv_start    (conv_start),
        .conv_sgl      (conv_sgl),
        .conv_odd      (conv_odd),
        .conv_done     (conv_done),
        .conv_data     (conv_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overrun       (overrun),
        .timeout       (timeout)
    );

    // Engine model: answers eng_lat cycles after conv_start.
    initial begin
        logic ch;
        conv_done = 1'b0;
        conv_data = 12'h000;
        forever begin
            @(posedge clk);
            #1;
            if (conv_start && eng_on) begin
                ch = conv_odd;
                repeat (eng_lat) @(posedge clk);
                #1;
                conv_done = 1'b1;
                conv_data = ch ? 12'h123 : 12'hABC;
                @(posedge clk);
                #1;
                conv_done = 1'b0;
            end
        end
    end

    // Count issued conversions away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (conv_start) begin
                starts++;
                if (conv_odd) starts_odd1++;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        en = 2'b00;
        clr_err = 1'b0;
        m_axis_tready = 1'b1;
        eng_on = 1'b1;
        eng_lat = 4;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget, output bit ok, output int n);
        ok = 1'b0;
        n = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (conv_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_sample(
        input  int          budget,
        output bit          ok,
        output logic [15:0] d,
        output logic        u
    );
        ok = 1'b0;
        d = '0;
        u = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (m_axis_tvalid && m_axis_tready) begin
                d = m_axis_tdata;
                u = m_axis_tuser;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({conv_start, conv_sgl, conv_odd, overrun, timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {conv_start, conv_sgl, conv_odd, overrun, timeout});
        end
        checks++;
        if ({m_axis_tdata, m_axis_tuser, m_axis_tvalid} !== 18'h0) begin
            errors++;
            $display("FAIL reset_stream got %h want 0",
                     {m_axis_tdata, m_axis_tuser, m_axis_tvalid});
        end
        rst = 1'b0;
    endtask

    task automatic test_first_issue();
        bit ok;
        int n;
        int m;
        do_reset();
        en = 2'b01;
        wait_start(1200, ok, n);
        checks++;
        if (!ok || n != 1001) begin
            errors++;
            $display("FAIL first_latency got %0d (ok=%0d) want 1001", n, ok);
        end
        checks++;
        if ({conv_sgl, conv_odd} !== 2'b10) begin
            errors++;
            $display("FAIL first_cfg sgl/odd got %b want 10", {conv_sgl, conv_odd});
        end
        @(posedge clk);
        #1;
        checks++;
        if (conv_start !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse got %b want 0", conv_start);
        end
        m = 1;
        while (!m_axis_tvalid && m < 50) begin
            @(posedge clk);
            #1;
            m++;
        end
        checks++;
        if (m_axis_tvalid !== 1'b1 || m != 5) begin
            errors++;
            $display("FAIL done_to_valid got %0d cycles want 5", m);
        end
        checks++;
        if (m_axis_tdata !== 16'h0ABC || m_axis_tuser !== 1'b0) begin
            errors++;
            $display("FAIL first_sample got %h/%b want 0abc/0",
                     m_axis_tdata, m_axis_tuser);
        end
        en = 2'b00;
        idle(20);
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [15:0] d;
        logic u;
        logic [15:0] exp_d;
        do_reset();
        en = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_d = k[0] ? 16'h0123 : 16'h0ABC;
            wait_sample(3000, ok, d, u);
            checks++;
            if (!ok || u !== k[0] || d !== exp_d) begin
                errors++;
                $display("FAIL rr_sample%0d got ok=%0d %h/%b want %h/%b",
                         k, ok, d, u, exp_d, k[0]);
            end
        end
        checks++;
        if (overrun !== 2'b00) begin
            errors++;
            $display("FAIL rr_overrun got %b want 00", overrun);
        end
        en = 2'b00;
        idle(20);
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        int bad;
        int s0;
        logic [15:0] d;
        logic u;
        do_reset();
        en = 2'b01;
        m_axis_tready = 1'b0;
        n = 0;
        while (!m_axis_tvalid && n < 1200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0ABC) begin
            errors++;
            $display("FAIL bp_first got v=%b %h want 1 0abc",
                     m_axis_tvalid, m_axis_tdata);
        end
        s0 = starts;
        bad = 0;
        repeat (3000) begin
            @(posedge clk);
            #1;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0ABC) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stable got %0d unstable cycles want 0", bad);
        end
        checks++;
        if (starts != s0) begin
            errors++;
            $display("FAIL bp_no_start got %0d starts want 0", starts - s0);
        end
        checks++;
        if (overrun !== 2'b01) begin
            errors++;
            $display("FAIL bp_overrun got %b want 01", overrun);
        end
        m_axis_tready = 1'b1;
        wait_sample(100, ok, d, u);
        checks++;
        if (!ok || d !== 16'h0ABC || u !== 1'b0) begin
            errors++;
            $display("FAIL bp_next got ok=%0d %h/%b want 0abc/0", ok, d, u);
        end
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        checks++;
        if (overrun !== 2'b00 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL bp_clr got %b/%b want 00/0", overrun, timeout);
        end
        en = 2'b00;
        idle(20);
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        logic [15:0] d;
        logic u;
        do_reset();
        eng_on = 1'b0;
        en = 2'b01;
        wait_start(1200, ok, n);
        n = 0;
        while (!timeout && n < 20100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!ok || timeout !== 1'b1 || n != 20001) begin
            errors++;
            $display("FAIL tmo_latency got %0d (to=%b) want 20001", n, timeout);
        end
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_no_valid got %b want 0", m_axis_tvalid);
        end
        eng_on = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (conv_start !== 1'b1) begin
            errors++;
            $display("FAIL tmo_reissue got %b want 1", conv_start);
        end
        wait_sample(100, ok, d, u);
        checks++;
        if (!ok || d !== 16'h0ABC) begin
            errors++;
            $display("FAIL tmo_sample got ok=%0d %h want 0abc", ok, d);
        end
        checks++;
        if (timeout !== 1'b1 || overrun !== 2'b01) begin
            errors++;
            $display("FAIL tmo_sticky got %b/%b want 1/01", timeout, overrun);
        end
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        checks++;
        if (timeout !== 1'b0 || overrun !== 2'b00) begin
            errors++;
            $display("FAIL tmo_clr got %b/%b want 0/00", timeout, overrun);
        end
        en = 2'b00;
        idle(20);
    endtask

    task automatic test_reset_busy();
        bit ok;
        int n;
        int vseen;
        int s0;
        do_reset();
        eng_lat = 10;
        en = 2'b01;
        wait_start(1200, ok, n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        en = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        s0 = starts;
        vseen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (m_axis_tvalid) vseen++;
        end
        checks++;
        if (!ok || vseen != 0) begin
            errors++;
            $display("FAIL rst_busy_valid got %0d valid cycles want 0", vseen);
        end
        checks++;
        if (starts != s0) begin
            errors++;
            $display("FAIL rst_busy_start got %0d starts want 0", starts - s0);
        end
        eng_lat = 4;
    endtask

    task automatic test_en_drop();
        bit ok;
        int n;
        int s0;
        int s1;
        logic [15:0] d;
        logic u;
        do_reset();
        en = 2'b11;
        wait_start(1200, ok, n);
        checks++;
        if (!ok || conv_odd !== 1'b0) begin
            errors++;
            $display("FAIL drop_first_odd got %b want 0", conv_odd);
        end
        en = 2'b00;
        s1 = starts_odd1;
        wait_sample(100, ok, d, u);
        checks++;
        if (!ok || d !== 16'h0ABC || u !== 1'b0) begin
            errors++;
            $display("FAIL drop_inflight got ok=%0d %h/%b want 0abc/0", ok, d, u);
        end
        s0 = starts;
        idle(300);
        checks++;
        if (starts_odd1 != s1 || starts != s0) begin
            errors++;
            $display("FAIL drop_ch1_issued got %0d starts want 0",
                     starts - s0 + starts_odd1 - s1);
        end
    endtask

    initial begin
        test_reset();
        test_first_issue();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_busy();
        test_en_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
